// File: rtl/mouse_click_ctrl_if.sv
// rtl/mouse_click_ctrl_if.sv - mouse button/pointer/hotspot bus between mouse front end and click qualifier
interface mouse_click_ctrl_if #(
    parameter int NUM_BTN = 2
);
    logic                   leftButton;
    logic                   rightButton;
    logic [9:0]             mouse_x;
    logic [9:0]             mouse_y;
    logic [NUM_BTN-1:0]     btn_en;
    logic [10*NUM_BTN-1:0]  btn_x0;
    logic [10*NUM_BTN-1:0]  btn_x1;
    logic [10*NUM_BTN-1:0]  btn_y0;
    logic [10*NUM_BTN-1:0]  btn_y1;
    logic [NUM_BTN-1:0]     click;
    logic [NUM_BTN-1:0]     hover;
    logic                   armed;
    logic                   cancel;

    modport master (
        output leftButton, rightButton, mouse_x, mouse_y,
        output btn_en, btn_x0, btn_x1, btn_y0, btn_y1,
        input  click, hover, armed, cancel
    );

    modport slave (
        input  leftButton, rightButton, mouse_x, mouse_y,
        input  btn_en, btn_x0, btn_x1, btn_y0, btn_y1,
        output click, hover, armed, cancel
    );
endinterface

// File: rtl/mouse_click_ctrl.sv
// rtl/mouse_click_ctrl.sv - debounced mouse button to qualified one-cycle hotspot click pulses
module mouse_click_ctrl #(
    parameter int NUM_BTN      = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int MAX_HOLD_CYC = 4095
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    mouse_click_ctrl_if.slave     bus
);
    localparam int IDXW  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int DBW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HCW   = $clog2(MAX_HOLD_CYC + 1);
    localparam int QUIET = DEBOUNCE_CYC + 2;
    localparam int QW    = $clog2(QUIET + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_REL} state_t;

    state_t             r_state;
    logic               r_sync1, r_sync2, r_db;
    logic [DBW-1:0]     r_db_cnt;
    logic [QW-1:0]      r_quiet;
    logic [IDXW-1:0]    r_idx;
    logic [HCW-1:0]     r_hc;
    logic [NUM_BTN-1:0] r_click, r_hover;
    logic               r_armed, r_cancel;

    logic               w_db_next, w_rise, w_fall;
    logic [NUM_BTN-1:0] w_inside, w_win;
    logic               w_any, w_in_k, w_en_k, w_timeout;
    logic [IDXW-1:0]    w_win_idx;

    // Edges are taken from the next debounced value so the FSM reacts in the toggle cycle
    always_comb begin
        w_db_next = r_db;
        if ((r_sync2 != r_db) && (r_db_cnt == DBW'(DEBOUNCE_CYC - 1)))
            w_db_next = ~r_db;
    end
    assign w_rise = w_db_next & ~r_db;
    assign w_fall = ~w_db_next & r_db;

    always_comb begin
        w_inside  = '0;
        w_win     = '0;
        w_any     = 1'b0;
        w_win_idx = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            w_inside[k] = (bus.mouse_x >= bus.btn_x0[10*k +: 10]) && (bus.mouse_x <= bus.btn_x1[10*k +: 10]) &&
                          (bus.mouse_y >= bus.btn_y0[10*k +: 10]) && (bus.mouse_y <= bus.btn_y1[10*k +: 10]);
        end
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (w_inside[k] && bus.btn_en[k]) begin
                w_any     = 1'b1;
                w_win_idx = IDXW'(k);
                w_win     = '0;
                w_win[k]  = 1'b1;
            end
        end
    end

    assign w_in_k    = w_inside[r_idx];
    assign w_en_k    = bus.btn_en[r_idx];
    assign w_timeout = (r_hc >= HCW'(MAX_HOLD_CYC - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_WAIT_REL;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
            r_quiet  <= '0;
            r_idx    <= '0;
            r_hc     <= '0;
            r_click  <= '0;
            r_hover  <= '0;
            r_armed  <= 1'b0;
            r_cancel <= 1'b0;
        end else begin
            r_sync1 <= bus.leftButton | bus.rightButton;
            r_sync2 <= r_sync1;
            if ((r_sync2 != r_db) && (r_db_cnt != DBW'(DEBOUNCE_CYC - 1)))
                r_db_cnt <= r_db_cnt + 1'b1;
            else
                r_db_cnt <= '0;
            r_db <= w_db_next;
            // Quiet counter lets WAIT_REL exit after reset when nothing is held
            if (r_sync2)
                r_quiet <= '0;
            else if (r_quiet != QW'(QUIET))
                r_quiet <= r_quiet + 1'b1;
            r_hover  <= w_win;
            r_click  <= '0;
            r_cancel <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        if (w_any) begin
                            r_state <= S_ARMED;
                            r_idx   <= w_win_idx;
                            r_hc    <= '0;
                            r_armed <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_REL;
                        end
                    end
                end
                S_ARMED: begin
                    if (r_hc != HCW'(MAX_HOLD_CYC))
                        r_hc <= r_hc + 1'b1;
                    if (w_fall && w_in_k && w_en_k && (r_hc < HCW'(MAX_HOLD_CYC))) begin
                        r_click[r_idx] <= 1'b1;
                        r_armed        <= 1'b0;
                        r_state        <= S_IDLE;
                    end else if (!w_in_k || !w_en_k || w_timeout) begin
                        r_cancel <= 1'b1;
                        r_armed  <= 1'b0;
                        r_state  <= w_db_next ? S_WAIT_REL : S_IDLE;
                    end
                end
                S_WAIT_REL: begin
                    if (w_fall || (!r_db && (r_quiet == QW'(QUIET))))
                        r_state <= S_IDLE;
                end
                default: r_state <= S_WAIT_REL;
            endcase
        end
    end

    assign bus.click  = r_click;
    assign bus.hover  = r_hover;
    assign bus.armed  = r_armed;
    assign bus.cancel = r_cancel;
endmodule

// File: tb/tb_mouse_click_ctrl.sv
// tb/tb_mouse_click_ctrl.sv - scoreboard bench for mouse_click_ctrl
module tb_mouse_click_ctrl;
    localparam int NUM_BTN = 2;
    localparam int EV_CANCEL = 16;
    localparam int EV_BOTH   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   exp_q[$];
    int   act_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    mouse_click_ctrl_if #(.NUM_BTN(NUM_BTN)) bus ();

    mouse_click_ctrl #(
        .NUM_BTN(NUM_BTN), .DEBOUNCE_CYC(4), .MAX_HOLD_CYC(100)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.click != 0 && bus.cancel) act_q.push_back(EV_BOTH);
            else if (bus.click != 0)          act_q.push_back(int'(bus.click));
            else if (bus.cancel)              act_q.push_back(EV_CANCEL);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move(input int x, input int y);
        bus.mouse_x = 10'(x);
        bus.mouse_y = 10'(y);
    endtask

    task automatic test_reset;
        bus.leftButton = 0; bus.rightButton = 0; bus.btn_en = 2'b11;
        bus.btn_x0 = {10'd398, 10'd361}; bus.btn_x1 = {10'd403, 10'd367};
        bus.btn_y0 = {10'd246, 10'd244}; bus.btn_y1 = {10'd273, 10'd273};
        move(364, 250);
        rst_n = 0;
        cycles(3);
        n_checks++; if (bus.click !== 2'b00) $display("FAIL reset_click got %b want 00", bus.click); else n_pass++;
        n_checks++; if (bus.hover !== 2'b00) $display("FAIL reset_hover got %b want 00", bus.hover); else n_pass++;
        n_checks++; if (bus.armed !== 1'b0) $display("FAIL reset_armed got %b want 0", bus.armed); else n_pass++;
        n_checks++; if (bus.cancel !== 1'b0) $display("FAIL reset_cancel got %b want 0", bus.cancel); else n_pass++;
        rst_n = 1;
        cycles(2);
        n_checks++; if (bus.hover !== 2'b01) $display("FAIL hover0 got %b want 01", bus.hover); else n_pass++;
        cycles(10);
    endtask

    task automatic test_click;
        int n, e, a;
        move(364, 250);
        exp_q.push_back(1);
        bus.leftButton = 1;
        n = 0;
        while (bus.armed !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_checks++; if (n !== 6) $display("FAIL arm_latency got %0d want 6", n); else n_pass++;
        cycles(20 - n);
        bus.leftButton = 0;
        cycles(12);
        n_checks++; if (bus.armed !== 1'b0) $display("FAIL click_armed_after got %b want 0", bus.armed); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            n_checks++; if (a !== e) $display("FAIL click_event got %0d want %0d", a, e); else n_pass++;
        end
        n_checks++; if (act_q.size() !== 0) $display("FAIL click_extra got %0d events want 0", act_q.size()); else n_pass++;
        act_q.delete();
    endtask

    task automatic test_drag_cancel;
        int e, a;
        move(400, 260);
        exp_q.push_back(EV_CANCEL);
        exp_q.push_back(2);
        bus.leftButton = 1;
        cycles(10);
        n_checks++; if (bus.armed !== 1'b1) $display("FAIL drag_armed got %b want 1", bus.armed); else n_pass++;
        n_checks++; if (bus.hover !== 2'b10) $display("FAIL drag_hover got %b want 10", bus.hover); else n_pass++;
        move(500, 260);
        cycles(3);
        n_checks++; if (bus.armed !== 1'b0) $display("FAIL drag_disarm got %b want 0", bus.armed); else n_pass++;
        n_checks++; if (bus.hover !== 2'b00) $display("FAIL drag_hover_out got %b want 00", bus.hover); else n_pass++;
        move(400, 260);
        cycles(10);
        n_checks++; if (bus.armed !== 1'b0) $display("FAIL wait_rel_rearm got %b want 0", bus.armed); else n_pass++;
        bus.leftButton = 0;
        cycles(12);
        bus.leftButton = 1;
        cycles(12);
        bus.leftButton = 0;
        cycles(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            n_checks++; if (a !== e) $display("FAIL drag_event got %0d want %0d", a, e); else n_pass++;
        end
        n_checks++; if (act_q.size() !== 0) $display("FAIL drag_extra got %0d events want 0", act_q.size()); else n_pass++;
        act_q.delete();
    endtask

    task automatic test_timeout;
        int n, m, e, a;
        move(364, 250);
        exp_q.push_back(EV_CANCEL);
        bus.leftButton = 1;
        n = 0;
        while (bus.armed !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        m = 0;
        while (bus.cancel !== 1'b1 && m < 200) begin @(negedge clk); m++; end
        n_checks++; if (m !== 100) $display("FAIL timeout_cycles got %0d want 100", m); else n_pass++;
        cycles(150 - n - m);
        bus.leftButton = 0;
        cycles(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            n_checks++; if (a !== e) $display("FAIL timeout_event got %0d want %0d", a, e); else n_pass++;
        end
        n_checks++; if (act_q.size() !== 0) $display("FAIL timeout_extra got %0d events want 0", act_q.size()); else n_pass++;
        act_q.delete();
    endtask

    task automatic test_glitch;
        bit seen_armed = 0;
        move(364, 250);
        for (int g = 0; g < 5; g++) begin
            bus.rightButton = 1;
            for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.armed) seen_armed = 1; end
            bus.rightButton = 0;
            for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.armed) seen_armed = 1; end
        end
        n_checks++; if (seen_armed !== 1'b0) $display("FAIL glitch_armed got 1 want 0"); else n_pass++;
        n_checks++; if (act_q.size() !== 0) $display("FAIL glitch_events got %0d want 0", act_q.size()); else n_pass++;
        act_q.delete();
    endtask

    task automatic test_reset_held;
        int e, a;
        move(364, 250);
        bus.leftButton = 1;
        cycles(2);
        rst_n = 0;
        cycles(3);
        rst_n = 1;
        cycles(20);
        bus.leftButton = 0;
        cycles(12);
        n_checks++; if (act_q.size() !== 0) $display("FAIL held_reset_events got %0d want 0", act_q.size()); else n_pass++;
        act_q.delete();
        exp_q.push_back(1);
        bus.leftButton = 1;
        cycles(15);
        bus.leftButton = 0;
        cycles(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            n_checks++; if (a !== e) $display("FAIL after_reset_event got %0d want %0d", a, e); else n_pass++;
        end
        n_checks++; if (act_q.size() !== 0) $display("FAIL after_reset_extra got %0d want 0", act_q.size()); else n_pass++;
        act_q.delete();
    endtask

    task automatic test_reset_mid_and_disable;
        int n;
        bit seen_armed = 0;
        move(364, 250);
        bus.leftButton = 1;
        n = 0;
        while (bus.armed !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_checks++; if (bus.armed !== 1'b1) $display("FAIL mid_armed got %b want 1", bus.armed); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_checks++; if ({bus.click, bus.hover, bus.armed, bus.cancel} !== 6'b0)
            $display("FAIL async_reset_outs got %b want 000000", {bus.click, bus.hover, bus.armed, bus.cancel});
        else n_pass++;
        bus.leftButton = 0;
        cycles(3);
        rst_n = 1;
        cycles(12);
        bus.btn_en = 2'b10;
        cycles(2);
        n_checks++; if (bus.hover !== 2'b00) $display("FAIL dis_hover got %b want 00", bus.hover); else n_pass++;
        bus.leftButton = 1;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (bus.armed) seen_armed = 1; end
        bus.leftButton = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (bus.armed) seen_armed = 1; end
        n_checks++; if (seen_armed !== 1'b0) $display("FAIL dis_armed got 1 want 0"); else n_pass++;
        n_checks++; if (act_q.size() !== 0) $display("FAIL dis_events got %0d want 0", act_q.size()); else n_pass++;
        act_q.delete();
        bus.btn_en = 2'b11;
    endtask

    initial begin
        test_reset;
        test_click;
        test_drag_cancel;
        test_timeout;
        test_glitch;
        test_reset_held;
        test_reset_mid_and_disable;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
